// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs format/fields/immediate into a 32-bit word
// behind a one-entry output register, expanding LI into LUI + ADDI when needed.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_fmt,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err
);
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        FULL_PEND = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] out_inst_r;
    logic        out_err_r;
    logic        out_valid_r;
    logic [31:0] pend_inst_r;

    logic        fits12_s, fits13_s, fits21_s;
    logic [19:0] hi_s;
    logic [11:0] lo_s;
    logic [31:0] pack_s, addi_s, enc_inst_s;
    logic        err_s, two_s, accept_s;

    // Operand range checks: a value fits in N bits when all bits above N-1 match its sign.
    always_comb begin
        fits12_s = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        fits13_s = (&in_imm[31:12]) | ~(|in_imm[31:12]);
        fits21_s = (&in_imm[31:20]) | ~(|in_imm[31:20]);
        // LI upper part compensates for ADDI sign-extending its low 12 bits
        hi_s     = in_imm[31:12] + {19'd0, in_imm[11]};
        lo_s     = in_imm[11:0];
    end

    // Field packing per format; rejected beats carry an all-zero word.
    always_comb begin
        pack_s = 32'd0;
        addi_s = 32'd0;
        err_s  = 1'b0;
        two_s  = 1'b0;
        case (in_fmt)
            4'd0: begin
                err_s  = ~fits12_s;
                pack_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            end
            4'd1: begin
                err_s  = ~fits12_s;
                pack_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            end
            4'd2: begin
                err_s  = ~fits13_s | in_imm[0];
                pack_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            4'd3: begin
                err_s  = |in_imm[11:0];
                pack_s = {in_imm[31:12], in_rd, OP_LUI};
            end
            4'd4: begin
                err_s  = |in_imm[11:0];
                pack_s = {in_imm[31:12], in_rd, OP_AUIPC};
            end
            4'd5: begin
                err_s  = ~fits21_s | in_imm[0];
                pack_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            end
            4'd6: begin
                err_s  = ~fits12_s;
                pack_s = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            end
            4'd7: begin
                err_s  = ~fits12_s;
                pack_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            end
            4'd8: begin
                if (hi_s == 20'd0) begin
                    pack_s = {lo_s, 5'd0, 3'b000, in_rd, OP_I};
                end else if (lo_s == 12'd0) begin
                    pack_s = {hi_s, in_rd, OP_LUI};
                end else begin
                    pack_s = {hi_s, in_rd, OP_LUI};
                    addi_s = {lo_s, in_rd, 3'b000, in_rd, OP_I};
                    two_s  = 1'b1;
                end
            end
            default: begin
                err_s  = 1'b1;
            end
        endcase
        enc_inst_s = err_s ? 32'd0 : pack_s;
    end

    assign in_ready  = (state_r == EMPTY) || ((state_r == FULL) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign out_inst  = out_inst_r;
    assign out_err   = out_err_r;

    // Output register FSM: load on accept, drain on handshake, release owed ADDI after LUI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            out_inst_r  <= 32'd0;
            out_err_r   <= 1'b0;
            pend_inst_r <= 32'd0;
        end else begin
            case (state_r)
                EMPTY, FULL: begin
                    if (accept_s) begin
                        out_inst_r  <= enc_inst_s;
                        out_err_r   <= err_s;
                        out_valid_r <= 1'b1;
                        pend_inst_r <= addi_s;
                        state_r     <= two_s ? FULL_PEND : FULL;
                    end else if ((state_r == FULL) && out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= EMPTY;
                    end else begin
                        state_r     <= state_r;
                    end
                end
                FULL_PEND: begin
                    if (out_ready) begin
                        out_inst_r  <= pend_inst_r;
                        out_err_r   <= 1'b0;
                        pend_inst_r <= 32'd0;
                        state_r     <= FULL;
                    end else begin
                        state_r     <= FULL_PEND;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
